multdiv_sequencer: RTL and testbench

Control stage directly upstream of the radix-4 Booth multiplier and the divider datapath.
- Accepts single-cycle ctrl_MULT / ctrl_DIV requests and latches both operands.
- Drives the shared 32-bit iteration counter that both datapaths consume.
- Captures the selected datapath's result and exception at the final iteration, then presents them with a one-cycle data_resultRDY strobe.
- Is the only block that knows operation latency; the datapaths remain purely counter-driven.

---
 rtl/multdiv_sequencer.sv | 145 ++++++++++++++
 tb/tb_multdiv_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: control stage for the radix-4 Booth multiplier and the
// restoring divider. Latches operands on a start pulse, drives the shared
// iteration counter, captures the selected datapath's result and exception
// on the final iteration and announces completion with a one-cycle strobe.
//
// Ports:
//   clk, reset                   clock, async active-high reset
//   ctrl_MULT, ctrl_DIV          start pulses (multiply has priority)
//   data_operandA/B              operands, sampled on the start edge
//   mult_result, mult_overflow   multiplier datapath outputs
//   div_result, div_exception    divider datapath outputs
//   op_a, op_b                   latched operands to both datapaths
//   counter                      iteration count to both datapaths
//   busy                         operation in flight
//   data_result, data_exception  held result of last completed operation
//   data_resultRDY               one-cycle completion strobe
module multdiv_sequencer #(
    parameter int unsigned MULT_CYCLES = 17,
    parameter int unsigned DIV_CYCLES  = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [31:0] mult_result,
    input  logic        mult_overflow,
    input  logic [31:0] div_result,
    input  logic        div_exception,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [31:0] counter,
    output logic        busy,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    localparam logic [31:0] MULT_LAST = 32'(MULT_CYCLES - 1);
    localparam logic [31:0] DIV_LAST  = 32'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_MULT = 2'd1,
        RUN_DIV  = 2'd2,
        DZERO    = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [31:0] op_a_next, op_b_next, counter_next, result_next;
    logic        exception_next, rdy_next, busy_next;

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            op_a           <= '0;
            op_b           <= '0;
            counter        <= '0;
            busy           <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            state          <= state_next;
            op_a           <= op_a_next;
            op_b           <= op_b_next;
            counter        <= counter_next;
            busy           <= busy_next;
            data_result    <= result_next;
            data_exception <= exception_next;
            data_resultRDY <= rdy_next;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_next     = state;
        op_a_next      = op_a;
        op_b_next      = op_b;
        counter_next   = counter;
        result_next    = data_result;
        exception_next = data_exception;
        rdy_next       = 1'b0;

        case (state)
            IDLE: begin
                counter_next = '0;
            end
            RUN_MULT: begin
                if (counter == MULT_LAST) begin
                    result_next    = mult_result;
                    exception_next = mult_overflow;
                    rdy_next       = 1'b1;
                    counter_next   = '0;
                    state_next     = IDLE;
                end else begin
                    counter_next = counter + 32'd1;
                end
            end
            RUN_DIV: begin
                if (counter == DIV_LAST) begin
                    result_next    = div_result;
                    exception_next = div_exception;
                    rdy_next       = 1'b1;
                    counter_next   = '0;
                    state_next     = IDLE;
                end else begin
                    counter_next = counter + 32'd1;
                end
            end
            DZERO: begin
                result_next    = '0;
                exception_next = 1'b1;
                rdy_next       = 1'b1;
                state_next     = IDLE;
            end
            default: begin
                state_next   = IDLE;
                counter_next = '0;
            end
        endcase

        // A start overrides everything above: any in-flight operation is
        // abandoned, but a result captured on this same edge is kept with
        // its strobe suppressed.
        if (ctrl_MULT || ctrl_DIV) begin
            op_a_next    = data_operandA;
            op_b_next    = data_operandB;
            counter_next = '0;
            rdy_next     = 1'b0;
            if (ctrl_MULT) begin
                state_next = RUN_MULT;
            end else if (data_operandB == 32'd0) begin
                state_next = DZERO;
            end else begin
                state_next = RUN_DIV;
            end
        end

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer. The datapaths are stood in for
// by behavioural models that only present a valid answer on the final
// iteration count, so a capture on the wrong cycle produces garbage.
module tb_multdiv_sequencer;

    localparam int MULT_LAT = 17;
    localparam int DIV_LAT  = 33;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB;
    logic [31:0] mult_result, div_result;
    logic        mult_overflow, div_exception;
    logic [31:0] op_a, op_b, counter, data_result;
    logic        busy, data_exception, data_resultRDY;

    int checks = 0;
    int errors = 0;

    multdiv_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .mult_result    (mult_result),
        .mult_overflow  (mult_overflow),
        .div_result     (div_result),
        .div_exception  (div_exception),
        .op_a           (op_a),
        .op_b           (op_b),
        .counter        (counter),
        .busy           (busy),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: valid product only on the last Booth iteration
    always_comb begin
        longint p;
        p = longint'($signed(op_a)) * longint'($signed(op_b));
        if (counter == 32'(MULT_LAT - 1)) begin
            mult_result   = p[31:0];
            mult_overflow = (p != longint'($signed(p[31:0])));
        end else begin
            mult_result   = 32'hA5A5_0000 | {16'h0, counter[15:0]};
            mult_overflow = counter[0];
        end
    end

    // Divider stand-in: valid quotient only on the last restoring iteration
    always_comb begin
        int ai, bi;
        ai = op_a;
        bi = op_b;
        if (counter == 32'(DIV_LAT - 1) && bi != 0) begin
            div_result    = 32'(ai / bi);
            div_exception = 1'b0;
        end else begin
            div_result    = 32'h5A5A_0000 | {16'h0, counter[15:0]};
            div_exception = ~counter[0];
        end
    end

    // Present a start pulse; returns #1 after the start edge with ctrl low
    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clk); #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Advance n edges, checking no strobe appears
    task automatic run_edges(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            data_operandA = $urandom;
            data_operandB = $urandom;
            checks++;
            if (data_resultRDY !== 1'b0) begin
                errors++;
                $display("FAIL %s early_rdy: rdy=%b required 0", name, data_resultRDY);
            end
        end
    endtask

    // Entered #1 after the start edge; waits for the strobe and checks it
    task automatic wait_done(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_res, input logic exp_exc,
                             input int exp_lat, input string name);
        int edges = 0;
        while (data_resultRDY !== 1'b1 && edges < 100) begin
            checks++;
            if (op_a !== a || op_b !== b) begin
                errors++;
                $display("FAIL %s op_latch: op_a=%h op_b=%h required %h %h", name, op_a, op_b, a, b);
            end
            checks++;
            if (counter !== 32'(edges) || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s counter: counter=%0d busy=%b required %0d busy 1", name, counter, busy, edges);
            end
            @(posedge clk); #1;
            edges++;
            data_operandA = $urandom;
            data_operandB = $urandom;
        end
        checks++;
        if (edges !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d edges required %0d", name, edges, exp_lat);
        end
        checks++;
        if (data_result !== exp_res || data_exception !== exp_exc) begin
            errors++;
            $display("FAIL %s result: got %h exc %b required %h exc %b", name, data_result, data_exception, exp_res, exp_exc);
        end
        checks++;
        if (busy !== 1'b0 || counter !== 32'd0) begin
            errors++;
            $display("FAIL %s idle_after: busy=%b counter=%0d required 0 0", name, busy, counter);
        end
        @(posedge clk); #1;
        checks++;
        if (data_resultRDY !== 1'b0 || data_result !== exp_res || data_exception !== exp_exc) begin
            errors++;
            $display("FAIL %s hold: rdy=%b result=%h exc=%b required 0 %h %b", name, data_resultRDY, data_result, data_exception, exp_res, exp_exc);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (op_a !== 32'd0 || op_b !== 32'd0 || counter !== 32'd0 || data_result !== 32'd0 ||
            data_exception !== 1'b0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s zero: op_a=%h op_b=%h cnt=%0d res=%h exc=%b rdy=%b busy=%b required all 0",
                     name, op_a, op_b, counter, data_result, data_exception, data_resultRDY, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = 32'd0; data_operandB = 32'd0;
        #1;
        check_all_zero("reset_async");
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_held");
        reset = 1'b0;
        @(posedge clk); #1;
        check_all_zero("reset_released");
    endtask

    task automatic test_mult();
        issue(1'b1, 1'b0, 32'd6, 32'd7);
        wait_done(32'd6, 32'd7, 32'd42, 1'b0, MULT_LAT, "mult_6x7");
        issue(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5);
        wait_done(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, MULT_LAT, "mult_neg");
        issue(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2);
        wait_done(32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, MULT_LAT, "mult_ovf");
    endtask

    task automatic test_div();
        issue(1'b0, 1'b1, 32'd100, 32'd7);
        wait_done(32'd100, 32'd7, 32'd14, 1'b0, DIV_LAT, "div_100_7");
        issue(1'b0, 1'b1, 32'd5, 32'd0);
        wait_done(32'd5, 32'd0, 32'd0, 1'b1, 1, "div_by_zero");
    endtask

    task automatic test_priority();
        issue(1'b1, 1'b1, 32'd2, 32'd3);
        wait_done(32'd2, 32'd3, 32'd6, 1'b0, MULT_LAT, "mult_div_both");
    endtask

    task automatic test_restart();
        issue(1'b1, 1'b0, 32'd3, 32'd3);
        run_edges(8, "restart_first");
        checks++;
        if (counter !== 32'd8) begin
            errors++;
            $display("FAIL restart_cnt8: counter=%0d required 8", counter);
        end
        issue(1'b1, 1'b0, 32'd4, 32'd5);
        wait_done(32'd4, 32'd5, 32'd20, 1'b0, MULT_LAT, "restart_second");
    endtask

    task automatic test_start_on_completion();
        issue(1'b1, 1'b0, 32'd6, 32'd7);
        run_edges(MULT_LAT - 1, "collide_mult");
        issue(1'b0, 1'b1, 32'd100, 32'd7);
        checks++;
        if (data_resultRDY !== 1'b0 || data_result !== 32'd42 || data_exception !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL collide_capture: rdy=%b res=%h exc=%b busy=%b required 0 0000002a 0 1",
                     data_resultRDY, data_result, data_exception, busy);
        end
        wait_done(32'd100, 32'd7, 32'd14, 1'b0, DIV_LAT, "collide_div");
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 1'b0, 32'd9, 32'd9);
        run_edges(10, "rst_mid_run");
        reset = 1'b1;
        #1;
        check_all_zero("rst_mid_async");
        @(posedge clk); #1;
        check_all_zero("rst_mid_held");
        reset = 1'b0;
        @(posedge clk); #1;
        issue(1'b1, 1'b0, 32'd6, 32'd7);
        wait_done(32'd6, 32'd7, 32'd42, 1'b0, MULT_LAT, "rst_mid_after");
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a, b, er;
            logic        ee;
            int          kind;
            kind = int'($urandom_range(0, 2));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                a = 32'($signed(16'($urandom)));
                b = 32'($signed(8'($urandom)));
            end
            if (kind == 0) begin
                longint p;
                p  = longint'($signed(a)) * longint'($signed(b));
                er = p[31:0];
                ee = (p > 64'sd2147483647) || (p < -64'sd2147483648);
                issue(1'b1, 1'b0, a, b);
                wait_done(a, b, er, ee, MULT_LAT, "rand_mult");
            end else if (kind == 1) begin
                int ai, bi;
                if (b == 32'd0 || b == 32'hFFFF_FFFF) b = 32'd3;
                ai = a;
                bi = b;
                er = 32'(ai / bi);
                issue(1'b0, 1'b1, a, b);
                wait_done(a, b, er, 1'b0, DIV_LAT, "rand_div");
            end else begin
                issue(1'b0, 1'b1, a, 32'd0);
                wait_done(a, 32'd0, 32'd0, 1'b1, 1, "rand_dzero");
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_priority();
        test_restart();
        test_start_on_completion();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
